wb_bram_arb: RTL and testbench
==============================

WB_BRAM_ARB -- requirements
Module: wb_bram_arb

Interface
REQ-001 Parameter AW, default 14, byte-address width of master and slave address buses.
REQ-002 Parameter TIMEOUT, default 255, max cycles a granted bus may wait for slave ack (range 2..255).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_adr_i/m0_dat_i/m0_sel_i/m0_we_i/m0_cyc_i/m0_stb_i  input  AW/32/4/1/1/1  master 0 (data port) Wishbone request.
REQ-006 m0_dat_o/m0_ack_o/m0_err_o  output  32/1/1  master 0 read data, ack, error.
REQ-007 m1_* ports  same widths/directions as m0_*  master 1 (instruction fetch port).
REQ-008 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o  output  AW/32/4/1/1/1  shared slave (single-port BRAM) request.
REQ-009 s_dat_i/s_ack_i  input  32/1  slave read data and ack.
REQ-010 gnt_o  output  2  one-hot current grant (bit n = master n); 2'b00 when idle.

Function
REQ-011 State machine SHALL have states IDLE, BUSY0, BUSY1; state and last-granted pointer (last) are registered.
REQ-012 Request n is defined as mn_cyc_i && mn_stb_i.
REQ-013 IDLE: no request -> IDLE; only req0 -> BUSY0; only req1 -> BUSY1; both -> BUSY of the master != last.
REQ-014 On entering BUSYn, last SHALL be set to n.
REQ-015 BUSYn: stays while mn_cyc_i=1 and no timeout; grant is held across multiple transfers (cyc-locked bursts).
REQ-016 BUSYn with mn_cyc_i=0: if other master requesting -> BUSY(other) directly, else IDLE.
REQ-017 Grant is registered: request first seen in IDLE at edge N drives slave from cycle N+1; no combinational path from mn_cyc_i to gnt_o.
REQ-018 In BUSYn, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL equal master n's inputs combinationally.
REQ-019 In IDLE, s_cyc_o, s_stb_o, s_we_o SHALL be 0; s_adr_o/s_dat_o/s_sel_o SHALL be 0.
REQ-020 mn_ack_o = s_ack_i && (state==BUSYn); non-granted master ack is always 0.
REQ-021 m0_dat_o and m1_dat_o SHALL both equal s_dat_i (validity qualified by ack).
REQ-022 Timeout counter: 8 bit, cleared on grant change, on s_ack_i=1 and when s_stb_o=0; increments each BUSY cycle with s_stb_o=1 and s_ack_i=0, saturating.
REQ-023 When counter reaches TIMEOUT with s_ack_i=0: mn_err_o pulses 1 cycle for granted master, next state IDLE, s_cyc_o deasserted in following cycle.
REQ-024 s_ack_i in the same cycle as the timeout threshold takes precedence: ack delivered, no err, no forced release.
REQ-025 mn_err_o and mn_ack_o SHALL never be 1 in the same cycle.
REQ-026 s_ack_i arriving in IDLE SHALL be dropped (no master ack).
REQ-027 Simultaneous release by granted master and request by other: handoff in one cycle with no IDLE cycle between.

Reset
REQ-028 While rst=1: state=IDLE, last=1 (master 0 wins first tie), counter=0, gnt_o=2'b00, all mn_ack_o/mn_err_o=0, s_cyc_o=s_stb_o=0.
REQ-029 rst asserted mid-transfer SHALL abort the grant at the next edge regardless of cyc/ack; slave ack after reset is dropped per REQ-026.

Verification
REQ-030 After reset, m0 and m1 request same cycle -> gnt_o=2'b01 next cycle, then after m0 drops cyc gnt_o=2'b10 with no idle gap.
REQ-031 Both masters request continuously with single-transfer cycles -> grants alternate 01,10,01,10; each master receives exactly one ack per transfer.
REQ-032 m1 burst of 4 reads (cyc held, BRAM 1-cycle ack) while m0 requests -> m0 waits until m1 drops cyc; m0_ack_o stays 0 throughout.
REQ-033 m0 write adr=0x0010, dat=0xDEADBEEF, sel=4'b1111, then m1 read 0x0010 -> m1_dat_o=0xDEADBEEF with m1_ack_o=1.
REQ-034 Slave ack tied low, TIMEOUT=4, m0 requests -> m0_err_o pulses once, 4 stalled cycles after s_stb_o rises; state IDLE, s_cyc_o=0 next cycle.
REQ-035 rst pulsed while BUSY1 mid-transfer -> gnt_o=2'b00, s_cyc_o=0 after edge; late s_ack_i produces no m1_ack_o.

Source files
------------

// File: rtl/wb_bram_arb.sv
// ----------------------------------------------------------------------------
// wb_bram_arb
// Two-master Wishbone arbiter in front of a single-port block RAM.
// Master 0 is the data port, master 1 the instruction-fetch port. A granted
// master keeps the bus for as long as it holds cyc, so bursts are never
// interleaved. When both masters ask at once from idle, the one that was not
// served last wins. A stalled slave is released after TIMEOUT cycles without
// an ack, and the granted master gets a one-cycle error pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m0_*_i / m0_*_o          master 0 request in, read data / ack / err out
//   m1_*_i / m1_*_o          master 1 request in, read data / ack / err out
//   s_*_o                    request forwarded to the shared slave
//   s_dat_i, s_ack_i         slave read data and ack
//   gnt_o                    one-hot current grant, 2'b00 while idle
// ----------------------------------------------------------------------------
module wb_bram_arb #(
    parameter int AW      = 14,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic req0, req1;
    logic timeout;

    assign req0 = m0_cyc_i && m0_stb_i;
    assign req1 = m1_cyc_i && m1_stb_i;

    // The slave side is a plain mux selected by the registered state, so the
    // grant never depends combinationally on a master's cyc.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_q)
            BUSY0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
            end
            BUSY1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
            end
            default: ;
        endcase
    end

    // An ack in the threshold cycle wins, so timeout is masked by s_ack_i.
    assign timeout = (state_q != IDLE) && s_stb_o && !s_ack_i
                     && (cnt_q >= TimeoutLim);

    // Next-state logic. A releasing master hands straight over to a waiting
    // one without passing through IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? BUSY0 : BUSY1;
                end else if (req0) begin
                    state_d = BUSY0;
                end else if (req1) begin
                    state_d = BUSY1;
                end
            end
            BUSY0: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (!m0_cyc_i) begin
                    state_d = req1 ? BUSY1 : IDLE;
                end
            end
            BUSY1: begin
                if (timeout) begin
                    state_d = IDLE;
                end else if (!m1_cyc_i) begin
                    state_d = req0 ? BUSY0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == BUSY0 && state_q != BUSY0) begin
            last_d = 1'b0;
        end else if (state_d == BUSY1 && state_q != BUSY1) begin
            last_d = 1'b1;
        end
    end

    // Stall counter: counts strobed cycles without ack, restarts on any
    // grant change, and saturates so it can never wrap past the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || s_ack_i || !s_stb_o) begin
            cnt_d = '0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State, last-served pointer and stall counter. Reset makes master 0
    // win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o    = {state_q == BUSY1, state_q == BUSY0};
    assign m0_ack_o = s_ack_i && (state_q == BUSY0);
    assign m1_ack_o = s_ack_i && (state_q == BUSY1);
    assign m0_err_o = timeout && (state_q == BUSY0);
    assign m1_err_o = timeout && (state_q == BUSY1);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_bram_arb.sv
// ----------------------------------------------------------------------------
// tb_wb_bram_arb
// Self-checking bench for wb_bram_arb built with TIMEOUT=4. A vector table
// drives the slave ack by hand to walk the arbitration and timeout paths;
// hand-written sequences then use a small one-cycle-ack BRAM model for
// handoff, alternation, bursts, write/read-back, timeout and mid-reset.
// ----------------------------------------------------------------------------
module tb_wb_bram_arb;

   localparam int AW = 14;
   localparam logic [AW-1:0] A0 = 14'h0010;
   localparam logic [AW-1:0] A1 = 14'h0020;
   localparam logic [31:0]   D0 = 32'h1111_0000;
   localparam logic [31:0]   D1 = 32'h2222_0000;

   logic clk;
   logic rst;

   logic          mCyc [2];
   logic          mStb [2];
   logic          mWe  [2];
   logic [AW-1:0] mAdr [2];
   logic [31:0]   mDat [2];
   logic [3:0]    mSel [2];

   logic [31:0] m0DatO, m1DatO;
   logic        m0AckO, m1AckO, m0ErrO, m1ErrO;
   logic [AW-1:0] sAdrO;
   logic [31:0] sDatO, sDatI;
   logic [3:0]  sSelO;
   logic        sWeO, sCycO, sStbO, sAckI;
   logic [1:0]  gntO;

   logic        bramEn;
   logic        useForce;
   logic        forceAck;
   logic [31:0] forceDat;
   logic        modelAck;
   logic [31:0] modelDat;
   logic [31:0] mem [16];

   int checks;
   int failures;
   int ackCnt0, ackCnt1, errCnt0, errCnt1;

   typedef struct packed {
      logic        r0;
      logic        r1;
      logic        ack;
      logic [31:0] sdat;
      logic [1:0]  eGnt;
      logic        eCyc;
      logic [AW-1:0] eAdr;
      logic [31:0] eSdo;
      logic        eAck0;
      logic        eAck1;
      logic        eErr0;
      logic        eErr1;
   } vec_t;

   vec_t vecs [20];

   wb_bram_arb #(.AW(AW), .TIMEOUT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_adr_i (mAdr[0]),
      .m0_dat_i (mDat[0]),
      .m0_sel_i (mSel[0]),
      .m0_we_i  (mWe[0]),
      .m0_cyc_i (mCyc[0]),
      .m0_stb_i (mStb[0]),
      .m0_dat_o (m0DatO),
      .m0_ack_o (m0AckO),
      .m0_err_o (m0ErrO),
      .m1_adr_i (mAdr[1]),
      .m1_dat_i (mDat[1]),
      .m1_sel_i (mSel[1]),
      .m1_we_i  (mWe[1]),
      .m1_cyc_i (mCyc[1]),
      .m1_stb_i (mStb[1]),
      .m1_dat_o (m1DatO),
      .m1_ack_o (m1AckO),
      .m1_err_o (m1ErrO),
      .s_adr_o  (sAdrO),
      .s_dat_o  (sDatO),
      .s_sel_o  (sSelO),
      .s_we_o   (sWeO),
      .s_cyc_o  (sCycO),
      .s_stb_o  (sStbO),
      .s_dat_i  (sDatI),
      .s_ack_i  (sAckI),
      .gnt_o    (gntO)
   );

   // 100 MHz-style free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave ack comes from the BRAM model or, for table vectors and late-ack
   // pokes, straight from the bench.
   assign sAckI = modelAck | forceAck;
   assign sDatI = useForce ? forceDat : modelDat;

   // One-cycle-ack BRAM model: acks the cycle after it sees a strobe and
   // never twice in a row, so a held strobe becomes one transfer.
   always @(posedge clk) begin
      if (rst) begin
         modelAck <= 1'b0;
      end else if (bramEn && sCycO && sStbO && !modelAck) begin
         modelAck <= 1'b1;
         modelDat <= mem[sAdrO[5:2]];
         if (sWeO) mem[sAdrO[5:2]] <= sDatO;
      end else begin
         modelAck <= 1'b0;
      end
   end

   // Running totals of ack and err pulses seen by each master.
   initial begin
      ackCnt0 = 0; ackCnt1 = 0; errCnt0 = 0; errCnt1 = 0;
   end
   always @(posedge clk) begin
      if (m0AckO) ackCnt0 <= ackCnt0 + 1;
      if (m1AckO) ackCnt1 <= ackCnt1 + 1;
      if (m0ErrO) errCnt0 <= errCnt0 + 1;
      if (m1ErrO) errCnt1 <= errCnt1 + 1;
   end

   // One comparison, one FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one table row onto both masters and the forced slave response.
   task automatic applyStimulus(input vec_t v);
      mCyc[0]  = v.r0;
      mStb[0]  = v.r0;
      mCyc[1]  = v.r1;
      mStb[1]  = v.r1;
      forceAck = v.ack;
      forceDat = v.sdat;
   endtask

   // Wait (bounded) for an ack to master m, sampling mid-cycle.
   task automatic waitAck(input int m, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         @(negedge clk);
         #2;
         n++;
         if ((m == 0) ? m0AckO : m1AckO) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL wait_ack_m%0d actual=none required=ack within 20 cycles", m);
      end
   endtask

   task automatic clearMasters();
      for (int i = 0; i < 2; i++) begin
         mCyc[i] = 1'b0;
         mStb[i] = 1'b0;
         mWe[i]  = 1'b0;
         mAdr[i] = '0;
         mDat[i] = '0;
         mSel[i] = 4'hF;
      end
   endtask

   // Hold reset across two edges, check the reset outputs, then release.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      clearMasters();
      forceAck = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      checkOutput("rst_gnt", 32'(gntO), 32'h0);
      checkOutput("rst_cyc", 32'(sCycO), 32'h0);
      checkOutput("rst_stb", 32'(sStbO), 32'h0);
      checkOutput("rst_ackerr", 32'({m0AckO, m1AckO, m0ErrO, m1ErrO}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit ok;
      int g;
      int base0, base1, baseE0, baseE1;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bramEn   = 1'b0;
      useForce = 1'b1;
      forceAck = 1'b0;
      forceDat = '0;
      clearMasters();

      //              r0 r1 ack sdat          gnt  cyc adr  sdo  a0 a1 e0 e1
      vecs[0]  = '{1'b0,1'b0,1'b0,32'hC000_0000,2'b00,1'b0,14'h0,32'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b1,1'b1,32'hC000_0001,2'b00,1'b0,14'h0,32'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b1,1'b0,32'hC000_0002,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b1,1'b1,1'b1,32'hC000_0003,2'b01,1'b1,A0,D0,1'b1,1'b0,1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b0,32'hC000_0004,2'b01,1'b0,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[5]  = '{1'b1,1'b1,1'b1,32'hC000_0005,2'b10,1'b1,A1,D1,1'b0,1'b1,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b0,32'hC000_0006,2'b10,1'b0,A1,D1,1'b0,1'b0,1'b0,1'b0};
      vecs[7]  = '{1'b1,1'b0,1'b0,32'hC000_0007,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b0,1'b0,32'hC000_0008,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[9]  = '{1'b1,1'b0,1'b0,32'hC000_0009,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[10] = '{1'b1,1'b0,1'b0,32'hC000_000A,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[11] = '{1'b1,1'b0,1'b0,32'hC000_000B,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b1,1'b0};
      vecs[12] = '{1'b1,1'b0,1'b0,32'hC000_000C,2'b00,1'b0,14'h0,32'h0,1'b0,1'b0,1'b0,1'b0};
      vecs[13] = '{1'b1,1'b0,1'b0,32'hC000_000D,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[14] = '{1'b1,1'b0,1'b0,32'hC000_000E,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[15] = '{1'b1,1'b0,1'b0,32'hC000_000F,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[16] = '{1'b1,1'b0,1'b0,32'hC000_0010,2'b01,1'b1,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[17] = '{1'b1,1'b0,1'b1,32'hC000_0011,2'b01,1'b1,A0,D0,1'b1,1'b0,1'b0,1'b0};
      vecs[18] = '{1'b0,1'b0,1'b0,32'hC000_0012,2'b01,1'b0,A0,D0,1'b0,1'b0,1'b0,1'b0};
      vecs[19] = '{1'b0,1'b0,1'b0,32'hC000_0013,2'b00,1'b0,14'h0,32'h0,1'b0,1'b0,1'b0,1'b0};

      // Table: arbitration, handoff, timeout and ack-at-threshold.
      doReset();
      mAdr[0] = A0; mDat[0] = D0; mSel[0] = 4'hF;
      mAdr[1] = A1; mDat[1] = D1; mSel[1] = 4'h3;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("v%0d_gnt", i),  32'(gntO),   32'(vecs[i].eGnt));
         checkOutput($sformatf("v%0d_cyc", i),  32'(sCycO),  32'(vecs[i].eCyc));
         checkOutput($sformatf("v%0d_adr", i),  32'(sAdrO),  32'(vecs[i].eAdr));
         checkOutput($sformatf("v%0d_sdo", i),  sDatO,       vecs[i].eSdo);
         checkOutput($sformatf("v%0d_ack0", i), 32'(m0AckO), 32'(vecs[i].eAck0));
         checkOutput($sformatf("v%0d_ack1", i), 32'(m1AckO), 32'(vecs[i].eAck1));
         checkOutput($sformatf("v%0d_err0", i), 32'(m0ErrO), 32'(vecs[i].eErr0));
         checkOutput($sformatf("v%0d_err1", i), 32'(m1ErrO), 32'(vecs[i].eErr1));
         checkOutput($sformatf("v%0d_m0dat", i), m0DatO,     vecs[i].sdat);
         checkOutput($sformatf("v%0d_m1dat", i), m1DatO,     vecs[i].sdat);
      end

      // Simultaneous request after reset, handoff without gap, write then
      // read-back through the other master.
      useForce = 1'b0;
      forceAck = 1'b0;
      bramEn   = 1'b1;
      doReset();
      @(negedge clk);
      mCyc[0] = 1; mStb[0] = 1; mWe[0] = 1; mAdr[0] = 14'h0010;
      mDat[0] = 32'hDEAD_BEEF; mSel[0] = 4'hF;
      mCyc[1] = 1; mStb[1] = 1; mWe[1] = 0; mAdr[1] = 14'h0010;
      #2;
      checkOutput("a_idle_gnt", 32'(gntO), 32'h0);
      @(negedge clk);
      #2;
      checkOutput("a_first_gnt", 32'(gntO), 32'h1);
      waitAck(0, ok);
      @(negedge clk);
      mCyc[0] = 0; mStb[0] = 0; mWe[0] = 0;
      #2;
      checkOutput("a_release_cyc", 32'(sCycO), 32'h0);
      @(negedge clk);
      #2;
      checkOutput("a_handoff_gnt", 32'(gntO), 32'h2);
      waitAck(1, ok);
      checkOutput("a_readback", m1DatO, 32'hDEAD_BEEF);
      checkOutput("a_m0_ack_off", 32'(m0AckO), 32'h0);
      @(negedge clk);
      mCyc[1] = 0; mStb[1] = 0;

      // Both masters request continuously with single transfers.
      doReset();
      base0 = ackCnt0; base1 = ackCnt1; baseE0 = errCnt0; baseE1 = errCnt1;
      @(negedge clk);
      mCyc[0] = 1; mStb[0] = 1; mAdr[0] = 14'h0010;
      mCyc[1] = 1; mStb[1] = 1; mAdr[1] = 14'h0020;
      g = 0;
      for (int r = 0; r < 4; r++) begin
         waitAck(g, ok);
         checkOutput($sformatf("alt%0d_gnt", r), 32'(gntO), (g == 0) ? 32'h1 : 32'h2);
         checkOutput($sformatf("alt%0d_other_ack", r),
                     32'((g == 0) ? m1AckO : m0AckO), 32'h0);
         @(negedge clk);
         mCyc[g] = 0; mStb[g] = 0;
         @(negedge clk);
         mCyc[g] = 1; mStb[g] = 1;
         g = 1 - g;
      end
      #2;
      checkOutput("alt_acks_m0", 32'(ackCnt0 - base0), 32'd2);
      checkOutput("alt_acks_m1", 32'(ackCnt1 - base1), 32'd2);
      clearMasters();

      // Master 1 four-beat burst while master 0 waits.
      doReset();
      base0 = ackCnt0;
      @(negedge clk);
      mCyc[1] = 1; mStb[1] = 1; mAdr[1] = 14'h0000;
      @(negedge clk);
      mCyc[0] = 1; mStb[0] = 1; mAdr[0] = 14'h0010;
      #2;
      checkOutput("b_gnt_m1", 32'(gntO), 32'h2);
      for (int b = 0; b < 4; b++) begin
         waitAck(1, ok);
         checkOutput($sformatf("b%0d_gnt", b), 32'(gntO), 32'h2);
         checkOutput($sformatf("b%0d_m0_ack", b), 32'(m0AckO), 32'h0);
         @(negedge clk);
         if (b == 3) begin
            mCyc[1] = 0; mStb[1] = 0;
         end else begin
            mAdr[1] = mAdr[1] + 14'd4;
         end
      end
      #2;
      checkOutput("b_m0_no_ack", 32'(ackCnt0 - base0), 32'd0);
      waitAck(0, ok);
      checkOutput("b_gnt_m0", 32'(gntO), 32'h1);
      checkOutput("b_no_err", 32'((errCnt0 - baseE0) + (errCnt1 - baseE1)), 32'd0);
      clearMasters();

      // Slave never acks: one error pulse four stalled cycles after strobe.
      bramEn = 1'b0;
      doReset();
      baseE0 = errCnt0;
      @(negedge clk);
      mCyc[0] = 1; mStb[0] = 1; mAdr[0] = 14'h0040;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 5) begin
            mCyc[0] = 0; mStb[0] = 0;
         end
         #2;
         if (k < 5) begin
            checkOutput($sformatf("t%0d_stb", k), 32'(sStbO), 32'h1);
            checkOutput($sformatf("t%0d_err", k), 32'(m0ErrO), (k == 4) ? 32'h1 : 32'h0);
         end else begin
            checkOutput("t_release_gnt", 32'(gntO), 32'h0);
            checkOutput("t_release_cyc", 32'(sCycO), 32'h0);
         end
      end
      checkOutput("t_err_count", 32'(errCnt0 - baseE0), 32'd1);

      // Reset mid-transfer on master 1, then a late slave ack.
      doReset();
      @(negedge clk);
      mCyc[1] = 1; mStb[1] = 1; mAdr[1] = 14'h0020;
      @(negedge clk);
      #2;
      checkOutput("r_gnt_busy1", 32'(gntO), 32'h2);
      checkOutput("r_cyc_busy1", 32'(sCycO), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mCyc[1] = 0; mStb[1] = 0;
      forceAck = 1'b1;
      #2;
      checkOutput("r_gnt_abort", 32'(gntO), 32'h0);
      checkOutput("r_cyc_abort", 32'(sCycO), 32'h0);
      checkOutput("r_late_ack_rst", 32'(m1AckO), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkOutput("r_late_ack_idle", 32'(m1AckO), 32'h0);
      forceAck = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
